store_buffer_n: RTL and testbench

- Parametrised committed-store buffer between the MEM stage and the d-cache write port.
- Successor to the single-entry store buffer: adds configurable depth, address/data width, in-order drain handshake and youngest-match load forwarding onto an sb_ifc-style output (sb_hit, valid, data).
- Stores retire into a circular FIFO and drain to the cache one per cycle when the cache accepts.
- Loads probe the buffer combinationally so read-after-store sees pending data.

---
 rtl/store_buffer_n.sv | 126 ++++++++++++
 tb/tb_store_buffer_n.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_n.sv
// Committed-store buffer: circular FIFO draining to the d-cache in order, with
// youngest-match load forwarding. Define SB_COALESCE_EN to merge same-address pushes.
module store_buffer_n #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    sb_hit,
    output logic                    sb_valid,
    output logic [DATA_W-1:0]       sb_data,
    output logic                    dr_valid,
    output logic [ADDR_W-1:0]       dr_addr,
    output logic [DATA_W-1:0]       dr_data,
    input  logic                    dr_ready,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pop;
    logic              push;
    logic              alloc;
    logic              coalesce;
    logic [PTR_W-1:0]  youngest;
    logic [DEPTH-1:0]  match;

    assign youngest = tail_q - PTR_W'(1);
    assign dr_valid = (count_q != '0);
    assign dr_addr  = addr_q[head_q];
    assign dr_data  = data_q[head_q];
    assign pop      = dr_valid && dr_ready;

`ifdef SB_COALESCE_EN
    // Merging into an entry that is leaving this cycle would lose the store.
    assign coalesce = st_valid && (count_q != '0) && valid_q[youngest]
                      && (addr_q[youngest] == st_addr)
                      && !((youngest == head_q) && pop);
`else
    assign coalesce = 1'b0;
`endif

    assign st_ready = (count_q != FULL_CNT) || pop || coalesce;
    assign push     = st_valid && st_ready;
    assign alloc    = push && !coalesce;
    assign empty    = (count_q == '0);
    assign count    = count_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = ld_valid && valid_q[gi] && (addr_q[gi] == ld_addr);
        end
    endgenerate

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        sb_hit  = 1'b0;
        sb_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[head_q + PTR_W'(i)]) begin
                sb_hit  = 1'b1;
                sb_data = data_q[head_q + PTR_W'(i)];
            end
        end
    end
    assign sb_valid = sb_hit;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)   head_d = head_q + PTR_W'(1);
        if (alloc) tail_d = tail_q + PTR_W'(1);
        case ({alloc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // When full, head==tail: the allocate must win over the pop clear.
            if (pop)   valid_q[head_q] <= 1'b0;
            if (alloc) valid_q[tail_q] <= 1'b1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
            end else if (coalesce) begin
                data_q[youngest] <= st_data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer_n.sv
// Directed bench for store_buffer_n (DEPTH=4): push/drain, forwarding, full, wrap, reset.
module tb_store_buffer_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        sb_hit;
    logic        sb_valid;
    logic [31:0] sb_data;
    logic        dr_valid;
    logic [31:0] dr_addr;
    logic [31:0] dr_data;
    logic        dr_ready;
    logic        empty;
    logic [2:0]  count;

    int total  = 0;
    int passed = 0;

    store_buffer_n #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .sb_hit(sb_hit), .sb_valid(sb_valid), .sb_data(sb_data),
        .dr_valid(dr_valid), .dr_addr(dr_addr), .dr_data(dr_data), .dr_ready(dr_ready),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [31:0] a);
        ld_valid = 1'b1;
        ld_addr  = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; dr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dr_valid", 64'(dr_valid), 64'd0);
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_sb_hit", 64'(sb_hit), 64'd0);
        chk("rst_sb_valid", 64'(sb_valid), 64'd0);
        chk("rst_sb_data", 64'(sb_data), 64'd0);

        // Two stores, no drain, then probes
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'h11; tick();
        st_addr = 32'h104; st_data = 32'h22; tick();
        st_valid = 1'b0;
        probe(32'h104);
        chk("fwd_b_hit", 64'(sb_hit), 64'd1);
        chk("fwd_b_valid", 64'(sb_valid), 64'd1);
        chk("fwd_b_data", 64'(sb_data), 64'h22);
        chk("ab_count", 64'(count), 64'd2);
        chk("ab_dr_addr", 64'(dr_addr), 64'h100);
        chk("ab_dr_data", 64'(dr_data), 64'h11);
        probe(32'h100);
        chk("fwd_a_data", 64'(sb_data), 64'h11);
        probe(32'h108);
        chk("miss_hit", 64'(sb_hit), 64'd0);
        chk("miss_data", 64'(sb_data), 64'd0);
        ld_valid = 1'b0;

        dr_ready = 1'b1; tick();
        chk("drain1_count", 64'(count), 64'd1);
        chk("drain1_addr", 64'(dr_addr), 64'h104);
        tick();
        chk("drain2_empty", 64'(empty), 64'd1);
        dr_ready = 1'b0;

        // Same address twice: youngest wins (or merges when coalescing)
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hAA; tick();
        st_data = 32'hBB; #1;
        chk("dup_st_ready", 64'(st_ready), 64'd1);
        tick();
        st_valid = 1'b0;
        probe(32'h200);
        chk("dup_fwd_data", 64'(sb_data), 64'hBB);
`ifdef SB_COALESCE_EN
        chk("dup_count", 64'(count), 64'd1);
        chk("dup_dr_data", 64'(dr_data), 64'hBB);
`else
        chk("dup_count", 64'(count), 64'd2);
        chk("dup_dr_data", 64'(dr_data), 64'hAA);
`endif
        ld_valid = 1'b0;
        dr_ready = 1'b1;
        for (int i = 0; i < 10 && !empty; i++) tick();
        chk("dup_drained", 64'(empty), 64'd1);
        dr_ready = 1'b0;

        // Fill to DEPTH, then stall and push-with-pop when full
        st_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'h10 + 32'(i); st_data = 32'hA0 + 32'(i); tick();
        end
        chk("full_count", 64'(count), 64'd4);
        st_addr = 32'h14; st_data = 32'hA4; #1;
        chk("full_st_ready", 64'(st_ready), 64'd0);
        tick();
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_addr", 64'(dr_addr), 64'h10);
        dr_ready = 1'b1; #1;
        chk("full_pop_st_ready", 64'(st_ready), 64'd1);
        tick();
        st_valid = 1'b0; dr_ready = 1'b0;
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_dr_addr", 64'(dr_addr), 64'h11);
        probe(32'h14);
        chk("wrap_fwd_hit", 64'(sb_hit), 64'd1);
        chk("wrap_fwd_data", 64'(sb_data), 64'hA4);
        probe(32'h10);
        chk("popped_miss", 64'(sb_hit), 64'd0);
        probe(32'h11);
        dr_ready = 1'b1; #1;
        chk("pop_fwd_data", 64'(sb_data), 64'hA1);
        ld_valid = 1'b0;
        for (int i = 0; i < 10 && !empty; i++) tick();
        chk("full_drained", 64'(empty), 64'd1);

        // Streaming six stores with the cache always ready
        for (int i = 0; i < 6; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(i); st_data = 32'hC0 + 32'(i); #1;
            if (i > 0) begin
                chk($sformatf("stream_addr%0d", i), 64'(dr_addr), 64'h40 + 64'(i - 1));
                chk($sformatf("stream_data%0d", i), 64'(dr_data), 64'hC0 + 64'(i - 1));
            end
            tick();
        end
        st_valid = 1'b0; #1;
        chk("stream_last_addr", 64'(dr_addr), 64'h45);
        chk("stream_last_count", 64'(count), 64'd1);
        tick();
        chk("stream_empty", 64'(empty), 64'd1);
        dr_ready = 1'b0;

        // A store pushed in the probe cycle is not forwarded
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h33;
        probe(32'h300);
        chk("same_cycle_no_fwd", 64'(sb_hit), 64'd0);
        tick();
        st_addr = 32'h304; st_data = 32'h34; #1;
        chk("next_cycle_fwd", 64'(sb_data), 64'h33);
        tick();
        ld_valid = 1'b0;
        st_addr = 32'h308; st_data = 32'h35; tick();
        st_valid = 1'b0; #1;
        chk("pre_rst_count", 64'(count), 64'd3);

        rst = 1'b1; tick(); rst = 1'b0;
        probe(32'h300);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_dr_valid", 64'(dr_valid), 64'd0);
        chk("mid_rst_sb_hit", 64'(sb_hit), 64'd0);
        ld_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
